tile_spawner: RTL and testbench

- Reads the 16-cell 2048 board after each move and picks one empty cell (value 0) using a random input.
- Writes a new tile into that cell: log2 value 1 (a "2" tile) or 2 (a "4" tile).
- Flags a full board when no empty cell exists.
- Sits between the move/merge logic and the board register bank. It is the per-turn counterpart of the initial two-tile placement.

---
 rtl/tile_spawner_if.sv | 25 ++
 rtl/tile_spawner.sv | 148 ++++++++++++++
 tb/tb_tile_spawner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_spawner_if.sv
// Handshake and board bus between the move/merge logic and the tile spawner.
// The master drives a request and board snapshot; the slave returns the updated board.
interface tile_spawner_if #(
    parameter int TILE_W = 4
);
    logic                   start;
    logic [7:0]             rand_in;
    logic [16*TILE_W-1:0]   board_in;
    logic [16*TILE_W-1:0]   board_out;
    logic [3:0]             spawn_idx;
    logic [TILE_W-1:0]      spawn_val;
    logic                   full;
    logic                   busy;
    logic                   done;

    modport master (
        output start, rand_in, board_in,
        input  board_out, spawn_idx, spawn_val, full, busy, done
    );

    modport slave (
        input  start, rand_in, board_in,
        output board_out, spawn_idx, spawn_val, full, busy, done
    );
endinterface

// File: rtl/tile_spawner.sv
// Per-turn 2048 tile spawner: counts empty cells, picks one using rand_in[3:0],
// and writes a 2- or 4-tile into it. A board with no empty cell is flagged full.
module tile_spawner #(
    parameter logic [3:0] FOUR_THRESH = 4'hF,
    parameter int         TILE_W      = 4
) (
    input  logic           clock,
    input  logic           resetn,
    tile_spawner_if.slave  bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_COUNT  = 3'd1;
    localparam logic [2:0] ST_SELECT = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [TILE_W-1:0] TILE_EMPTY = TILE_W'(0);
    localparam logic [TILE_W-1:0] TILE_TWO   = TILE_W'(1);
    localparam logic [TILE_W-1:0] TILE_FOUR  = TILE_W'(2);

    logic [2:0]             state_r;
    logic [16*TILE_W-1:0]   shadow_r;
    logic [7:0]             rand_r;
    logic [3:0]             idx_r;
    logic [4:0]             cnt_r;
    logic [4:0]             seen_r;
    logic [4:0]             target_r;
    logic [3:0]             pick_r;
    logic [16*TILE_W-1:0]   board_out_r;
    logic [3:0]             spawn_idx_r;
    logic [TILE_W-1:0]      spawn_val_r;
    logic                   full_r;
    logic                   busy_r;
    logic                   done_r;

    logic [TILE_W-1:0]      cell_s;
    logic                   cell_empty_s;
    logic [4:0]             cnt_inc_s;
    logic [8:0]             prod_s;
    logic [4:0]             target_s;
    logic [TILE_W-1:0]      spawn_tile_s;
    logic [16*TILE_W-1:0]   ins_board_s;

    assign cell_s       = shadow_r[idx_r*TILE_W +: TILE_W];
    assign cell_empty_s = (cell_s == TILE_EMPTY);
    assign cnt_inc_s    = cnt_r + {4'd0, cell_empty_s};
    // Scaling a 4-bit random by the empty count maps it onto 0..count-1.
    assign prod_s       = {5'd0, rand_r[3:0]} * {4'd0, cnt_inc_s};
    assign target_s     = 5'(prod_s >> 4);
    assign spawn_tile_s = (rand_r[7:4] >= FOUR_THRESH) ? TILE_FOUR : TILE_TWO;

    // Shadow board with the chosen cell replaced by the new tile.
    always_comb begin
        ins_board_s = shadow_r;
        ins_board_s[pick_r*TILE_W +: TILE_W] = spawn_tile_s;
    end

    // Spawn sequencer: scan/count, scan/select, write, then one-cycle done.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            shadow_r    <= '0;
            rand_r      <= 8'd0;
            idx_r       <= 4'd0;
            cnt_r       <= 5'd0;
            seen_r      <= 5'd0;
            target_r    <= 5'd0;
            pick_r      <= 4'd0;
            board_out_r <= '0;
            spawn_idx_r <= 4'd0;
            spawn_val_r <= TILE_EMPTY;
            full_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        shadow_r <= bus.board_in;
                        rand_r   <= bus.rand_in;
                        idx_r    <= 4'd0;
                        cnt_r    <= 5'd0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_COUNT;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    cnt_r <= cnt_inc_s;
                    if (idx_r == 4'd15) begin
                        idx_r <= 4'd0;
                        if (cnt_inc_s == 5'd0) begin
                            full_r      <= 1'b1;
                            spawn_val_r <= TILE_EMPTY;
                            board_out_r <= shadow_r;
                            done_r      <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            target_r <= target_s;
                            seen_r   <= 5'd0;
                            state_r  <= ST_SELECT;
                        end
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                ST_SELECT: begin
                    idx_r <= idx_r + 4'd1;
                    if (cell_empty_s) begin
                        if (seen_r == target_r) begin
                            pick_r  <= idx_r;
                            state_r <= ST_WRITE;
                        end else begin
                            seen_r  <= seen_r + 5'd1;
                        end
                    end else begin
                        seen_r <= seen_r;
                    end
                end
                ST_WRITE: begin
                    board_out_r <= ins_board_s;
                    spawn_idx_r <= pick_r;
                    spawn_val_r <= spawn_tile_s;
                    full_r      <= 1'b0;
                    done_r      <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.board_out = board_out_r;
    assign bus.spawn_idx = spawn_idx_r;
    assign bus.spawn_val = spawn_val_r;
    assign bus.full      = full_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: latency, chosen cell, tile value, full flag,
// ignored restarts and mid-operation reset.
module tb_tile_spawner;
    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    tile_spawner_if #(.TILE_W(4)) bus ();

    tile_spawner #(.FOUR_THRESH(4'hF), .TILE_W(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] make_board(input logic [3:0] fill, input logic [15:0] empty_mask);
        logic [63:0] b;
        b = 64'd0;
        for (int k = 0; k < 16; k++) b[4*k +: 4] = empty_mask[k] ? 4'd0 : fill;
        return b;
    endfunction

    function automatic logic [63:0] set_cell(input logic [63:0] b, input int k, input logic [3:0] v);
        logic [63:0] r;
        r = b;
        r[4*k +: 4] = v;
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (bus.busy && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_op(input logic [63:0] board, input logic [7:0] rnd, output int edges);
        wait_idle();
        bus.board_in = board;
        bus.rand_in  = rnd;
        bus.start    = 1'b1;
        @(posedge clock);
        edges = 1;
        #1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && edges < 64) begin
            @(posedge clock);
            edges++;
            #1;
        end
    endtask

    task automatic check_result(input string name, input int edges, input int exp_edges,
                                input logic [63:0] exp_board, input logic [3:0] exp_val,
                                input logic exp_full);
        checks++;
        if (edges !== exp_edges) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, exp_edges);
        end
        checks++;
        if (bus.board_out !== exp_board) begin
            errors++;
            $display("FAIL %s board_out: got %h, expected %h", name, bus.board_out, exp_board);
        end
        checks++;
        if (bus.spawn_val !== exp_val) begin
            errors++;
            $display("FAIL %s spawn_val: got %0d, expected %0d", name, bus.spawn_val, exp_val);
        end
        checks++;
        if (bus.full !== exp_full) begin
            errors++;
            $display("FAIL %s full: got %b, expected %b", name, bus.full, exp_full);
        end
    endtask

    task automatic check_idx(input string name, input logic [3:0] exp_idx);
        checks++;
        if (bus.spawn_idx !== exp_idx) begin
            errors++;
            $display("FAIL %s spawn_idx: got %0d, expected %0d", name, bus.spawn_idx, exp_idx);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({bus.board_out, bus.spawn_idx, bus.spawn_val, bus.full, bus.busy, bus.done} !== 75'd0) begin
            errors++;
            $display("FAIL %s outputs: got board=%h idx=%0d val=%0d full=%b busy=%b done=%b, expected all 0",
                     name, bus.board_out, bus.spawn_idx, bus.spawn_val, bus.full, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        bus.start    = 1'b0;
        bus.rand_in  = 8'd0;
        bus.board_in = 64'd0;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_empty_board();
        int edges;
        run_op(64'd0, 8'h00, edges);
        check_result("empty_board", edges, 19, 64'h0000_0000_0000_0001, 4'd1, 1'b0);
        check_idx("empty_board", 4'd0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_board busy_in_done: got %b, expected 1", bus.busy);
        end
    endtask

    task automatic test_full_board();
        int edges;
        run_op(64'h3333_3333_3333_3333, 8'hA5, edges);
        check_result("full_board", edges, 17, 64'h3333_3333_3333_3333, 4'd0, 1'b1);
    endtask

    task automatic test_single_empty();
        int edges;
        logic [63:0] b;
        b = make_board(4'd1, 16'h0200);
        run_op(b, 8'hF7, edges);
        check_result("single_empty", edges, 28, set_cell(b, 9, 4'd2), 4'd2, 1'b0);
        check_idx("single_empty", 4'd9);
    endtask

    task automatic test_four_empties();
        int edges;
        logic [63:0] b;
        b = make_board(4'd2, 16'h4422);
        run_op(b, 8'h0C, edges);
        check_result("four_empties", edges, 33, set_cell(b, 14, 4'd1), 4'd1, 1'b0);
        check_idx("four_empties", 4'd14);
    endtask

    task automatic test_ignore_start();
        int edges;
        int pulses;
        int first_done;
        logic [63:0] b;
        b = make_board(4'd1, 16'h0008);
        wait_idle();
        bus.board_in = b;
        bus.rand_in  = 8'h00;
        bus.start    = 1'b1;
        @(posedge clock);
        edges      = 1;
        pulses     = 0;
        first_done = 0;
        #1;
        bus.start = 1'b0;
        while (edges < 40) begin
            if (edges == 4) begin
                bus.start    = 1'b1;
                bus.board_in = 64'd0;
                bus.rand_in  = 8'hFF;
            end
            @(posedge clock);
            edges++;
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                if (first_done == 0) first_done = edges;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start done_pulses: got %0d, expected 1", pulses);
        end
        checks++;
        if (first_done !== 22) begin
            errors++;
            $display("FAIL ignore_start latency: got %0d, expected 22", first_done);
        end
        checks++;
        if (bus.board_out !== set_cell(b, 3, 4'd1)) begin
            errors++;
            $display("FAIL ignore_start board_out: got %h, expected %h", bus.board_out, set_cell(b, 3, 4'd1));
        end
        check_idx("ignore_start", 4'd3);
    endtask

    task automatic test_done_restart();
        int edges;
        run_op(64'd0, 8'h00, edges);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_restart start_in_done: busy got %b, expected 0", bus.busy);
        end
        @(posedge clock);
        edges = 1;
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL done_restart start_in_idle: busy got %b, expected 1", bus.busy);
        end
        while (bus.done !== 1'b1 && edges < 64) begin
            @(posedge clock);
            edges++;
            #1;
        end
        check_result("done_restart", edges, 19, 64'h0000_0000_0000_0001, 4'd1, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int edges;
        wait_idle();
        bus.board_in = make_board(4'd2, 16'h4422);
        bus.rand_in  = 8'h0C;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (18) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_zero_outputs("reset_mid_op");
        @(negedge clock);
        resetn = 1'b1;
        run_op(64'd0, 8'h00, edges);
        check_result("after_reset", edges, 19, 64'h0000_0000_0000_0001, 4'd1, 1'b0);
        check_idx("after_reset", 4'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_empty_board();
        test_full_board();
        test_single_empty();
        test_four_empties();
        test_ignore_start();
        test_done_restart();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
